// File: rtl/mips_instruction_opfunc_decode_queue_pkg.sv
// Shared opFunc definitions for the fetch-to-decode instruction queue:
// source encodings, the REGIMM opcode and the tag width helper.
package mips_instruction_opfunc_decode_queue_pkg;

  localparam int SOURCE_W = 2;

  typedef enum logic [SOURCE_W-1:0] {
    SOURCE_FUNC   = 2'd0,
    SOURCE_OP     = 2'd1,
    SOURCE_REGIMM = 2'd2
  } source_e;

  localparam logic [5:0] OP_SPECIAL = 6'd0;
  localparam logic [5:0] OP_REGIMM  = 6'd1;

  function automatic int opFuncWidth(input int codeW);
    return SOURCE_W + codeW;
  endfunction

endpackage

// File: rtl/mips_instruction_opfunc_decode_queue_lane_decode.sv
// Combinational split of one 32-bit MIPS instruction into its {source, code} tag.
module mips_instruction_opfunc_lane_decode
  import mips_instruction_opfunc_decode_queue_pkg::*;
#(
  parameter bit REGIMM_EN = 1'b1,
  parameter int CODE_W    = 6
) (
  input  logic [31:0]                inst,
  output logic [SOURCE_W+CODE_W-1:0] opFunc
);

  logic [5:0]        op;
  source_e           source;
  logic [CODE_W-1:0] code;
  logic              unusedBits;

  assign op         = inst[31:26];
  assign unusedBits = ^{inst[25:21], inst[15:6]};

  // SPECIAL takes its code from func, REGIMM from rt, everything else from op
  always_comb begin
    source = SOURCE_OP;
    code   = CODE_W'(op);
    if (op == OP_SPECIAL) begin
      source = SOURCE_FUNC;
      code   = CODE_W'(inst[5:0]);
    end else if ((op == OP_REGIMM) && REGIMM_EN) begin
      source = SOURCE_REGIMM;
      code   = CODE_W'(inst[20:16]);
    end
  end

  assign opFunc = {source, code};

endmodule

// File: rtl/mips_instruction_opfunc_decode_queue.sv
// Multi-lane opFunc decoder feeding a DEPTH-entry FIFO between fetch and decode,
// with valid/ready on both sides and a flush for branch redirect.
module mips_instruction_opfunc_decode_queue
  import mips_instruction_opfunc_decode_queue_pkg::*;
#(
  parameter int LANES     = 2,
  parameter int DEPTH     = 4,
  parameter bit REGIMM_EN = 1'b1,
  parameter int CODE_W    = 6,
  localparam int OF_W     = SOURCE_W + CODE_W,
  localparam int PTR_W    = $clog2(DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [LANES*32-1:0]   inInst,
  input  logic [LANES-1:0]      inMask,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [LANES*OF_W-1:0] outOpFunc,
  output logic [LANES-1:0]      outMask,
  output logic [PTR_W-1:0]      count
);

  localparam int ADDR_W  = PTR_W - 1;
  localparam int TAGS_W  = LANES * opFuncWidth(CODE_W);
  localparam int ENTRY_W = TAGS_W + LANES;

  logic [PTR_W-1:0]   wrPtr;
  logic [PTR_W-1:0]   rdPtr;
  logic [ENTRY_W-1:0] storage [DEPTH];
  logic [ENTRY_W-1:0] head;
  logic [TAGS_W-1:0]  decoded;
  logic [TAGS_W-1:0]  maskedOpFunc;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  // Masked-off lanes still occupy their slot but carry an all-zero tag
  for (genvar i = 0; i < LANES; i++) begin : gLane
    mips_instruction_opfunc_lane_decode #(
      .REGIMM_EN (REGIMM_EN),
      .CODE_W    (CODE_W)
    ) uLaneDecode (
      .inst   (inInst[32*i +: 32]),
      .opFunc (decoded[OF_W*i +: OF_W])
    );
    assign maskedOpFunc[OF_W*i +: OF_W] = inMask[i] ? decoded[OF_W*i +: OF_W] : '0;
  end

  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[PTR_W-1] != rdPtr[PTR_W-1]) &&
                 (wrPtr[ADDR_W-1:0] == rdPtr[ADDR_W-1:0]);

  assign inReady  = !full;
  assign outValid = !empty;
  assign push     = inValid && inReady && !flush;
  assign pop      = outValid && outReady && !flush;
  assign count    = wrPtr - rdPtr;

  // Reset beats flush, and flush beats any same-cycle push or pop
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else if (flush) begin
      rdPtr <= wrPtr;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) storage[wrPtr[ADDR_W-1:0]] <= {inMask, maskedOpFunc};
  end

  // Head is gated so an empty queue never exposes stale or uninitialised storage
  assign head      = storage[rdPtr[ADDR_W-1:0]];
  assign outOpFunc = outValid ? head[TAGS_W-1:0] : '0;
  assign outMask   = outValid ? head[ENTRY_W-1 -: LANES] : '0;

endmodule
